// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the memory-access stage.
package mem_lsu_pkg;

  localparam int XLEN   = 64;
  localparam int STRB_W = XLEN / 8;

  // Access size encodings carried in mem_size
  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;

  // Execute -> memory -> writeback pipeline record
  typedef struct packed {
    logic            is_valid;
    logic [63:0]     pc;
    logic [4:0]      rd;
    logic            rf_wr_en;
    logic            mem_rd;
    logic            mem_wr;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic [63:0]     mem_addr;
    logic [63:0]     mem_data;
    logic [63:0]     rf_wr_data;
  } interconnection_struct;

  // Low address bits that must be zero for a naturally aligned access
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    case (size)
      MEM_B:   size_mask = 3'b000;
      MEM_H:   size_mask = 3'b001;
      MEM_W:   size_mask = 3'b011;
      default: size_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational byte-lane logic: store strobe/data placement, load lane
// extraction with zero/sign extension, and the natural-alignment check.
module mem_lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [63:0] st_data,
  input  logic [63:0] ld_word,
  output logic [7:0]  strb,
  output logic [63:0] wdata,
  output logic [63:0] ld_result,
  output logic        misaligned
);

  logic [7:0]  base_strb;
  logic [63:0] lane;

  // Strobe/data placement and load extraction from the byte offset
  always_comb begin
    misaligned = |(offset & size_mask(size));

    case (size)
      MEM_B:   base_strb = 8'h01;
      MEM_H:   base_strb = 8'h03;
      MEM_W:   base_strb = 8'h0F;
      default: base_strb = 8'hFF;
    endcase
    strb  = base_strb << offset;
    wdata = st_data << {offset, 3'b000};

    lane = ld_word >> {offset, 3'b000};
    case (size)
      MEM_B:   ld_result = is_unsigned ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      MEM_H:   ld_result = is_unsigned ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      MEM_W:   ld_result = is_unsigned ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: ld_result = lane;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: issues one load/store at a time on a valid/ready port,
// stalls upstream while busy, and registers the result record for writeback.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN_P   = XLEN,
  parameter int STRB_W_P = XLEN_P / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  interconnection_struct i_struct,
  output logic                  o_stall,
  output interconnection_struct o_struct,
  output logic                  o_misaligned,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_req_we,
  output logic [XLEN_P-1:0]     dmem_req_addr,
  output logic [XLEN_P-1:0]     dmem_req_wdata,
  output logic [STRB_W_P-1:0]   dmem_req_strb,
  input  logic                  dmem_rsp_valid,
  input  logic [XLEN_P-1:0]     dmem_rsp_rdata
);

  mem_state_t            state;
  interconnection_struct cap;

  logic        mem_op;
  logic        idle;
  logic [2:0]  al_off;
  logic [1:0]  al_size;
  logic        al_uns;
  logic [7:0]  al_strb;
  logic [63:0] al_wdata;
  logic [63:0] al_ld;
  logic        al_mis;

  assign idle    = (state == IDLE);
  assign o_stall = !idle;
  assign mem_op  = i_struct.is_valid && (i_struct.mem_rd || i_struct.mem_wr);

  // Alignment logic looks at the incoming op in IDLE and the captured op otherwise
  always_comb begin
    al_off  = idle ? i_struct.mem_addr[2:0] : cap.mem_addr[2:0];
    al_size = idle ? i_struct.mem_size      : cap.mem_size;
    al_uns  = idle ? i_struct.mem_unsigned  : cap.mem_unsigned;
  end

  mem_lsu_align u_align (
    .offset      (al_off),
    .size        (al_size),
    .is_unsigned (al_uns),
    .st_data     (i_struct.mem_data),
    .ld_word     (dmem_rsp_rdata),
    .strb        (al_strb),
    .wdata       (al_wdata),
    .ld_result   (al_ld),
    .misaligned  (al_mis)
  );

  // Access FSM with registered request and writeback outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cap            <= '0;
      o_struct       <= '0;
      o_misaligned   <= 1'b0;
      dmem_req_valid <= 1'b0;
      dmem_req_we    <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_wdata <= '0;
      dmem_req_strb  <= '0;
    end else begin
      o_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_op) begin
            // Memory ops always leave a bubble; the result appears at completion
            o_struct.is_valid <= 1'b0;
            if (al_mis) begin
              o_misaligned <= 1'b1;
            end else begin
              cap            <= i_struct;
              dmem_req_valid <= 1'b1;
              dmem_req_we    <= i_struct.mem_wr;
              dmem_req_addr  <= {i_struct.mem_addr[63:3], 3'b000};
              dmem_req_wdata <= i_struct.mem_wr ? al_wdata : '0;
              dmem_req_strb  <= i_struct.mem_wr ? al_strb : '0;
              state          <= REQ;
            end
          end else if (i_struct.is_valid) begin
            o_struct <= i_struct;
          end else begin
            o_struct.is_valid <= 1'b0;
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            if (cap.mem_wr) begin
              o_struct <= cap;
              state    <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rsp_valid) begin
            o_struct            <= cap;
            o_struct.rf_wr_data <= al_ld;
            state               <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed and randomized checks of mem_lsu against an arithmetic reference model.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int SW = $bits(interconnection_struct);

  logic                  clk;
  logic                  rst_n;
  interconnection_struct i_struct;
  logic                  o_stall;
  interconnection_struct o_struct;
  logic                  o_misaligned;
  logic                  dmem_req_valid;
  logic                  dmem_req_ready;
  logic                  dmem_req_we;
  logic [63:0]           dmem_req_addr;
  logic [63:0]           dmem_req_wdata;
  logic [7:0]            dmem_req_strb;
  logic                  dmem_rsp_valid;
  logic [63:0]           dmem_rsp_rdata;

  int passed = 0;
  int total  = 0;

  mem_lsu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_struct       (i_struct),
    .o_stall        (o_stall),
    .o_struct       (o_struct),
    .o_misaligned   (o_misaligned),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_we    (dmem_req_we),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_req_strb  (dmem_req_strb),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic chk_s(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: pick the addressed bytes, then zero- or sign-extend
  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input logic [2:0] off,
                                           input logic [1:0] sz, input logic uns);
    int nb;
    logic [63:0] mask, v;
    nb   = 1 << sz;
    mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    v    = (rdata >> (8 * off)) & mask;
    if (!uns && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] ref_strb(input logic [2:0] off, input logic [1:0] sz);
    logic [15:0] t;
    t = ((16'd1 << (1 << sz)) - 16'd1) << off;
    return t[7:0];
  endfunction

  // Present one instruction in IDLE and play the memory side with the given delays
  task automatic do_op(input interconnection_struct s, input int rdy_dly, input int rsp_dly,
                       input logic [63:0] rdata);
    int nb;
    logic [2:0] off;
    interconnection_struct e;
    nb  = 1 << s.mem_size;
    off = s.mem_addr[2:0];
    @(negedge clk);
    i_struct = s; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    chk("stall_idle", {63'd0, o_stall}, 64'd0);
    @(negedge clk);
    i_struct = '0;
    if (!(s.is_valid && (s.mem_rd || s.mem_wr))) begin
      if (s.is_valid) chk_s("alu_out", o_struct, s);
      else chk("nop_valid", {63'd0, o_struct.is_valid}, 64'd0);
      chk("alu_stall", {63'd0, o_stall}, 64'd0);
      return;
    end
    if ((off % nb) != 0) begin
      chk("mis_pulse", {63'd0, o_misaligned}, 64'd1);
      chk("mis_valid", {63'd0, o_struct.is_valid}, 64'd0);
      chk("mis_req", {63'd0, dmem_req_valid}, 64'd0);
      chk("mis_stall", {63'd0, o_stall}, 64'd0);
      @(negedge clk);
      chk("mis_pulse_end", {63'd0, o_misaligned}, 64'd0);
      chk("mis_req2", {63'd0, dmem_req_valid}, 64'd0);
      return;
    end
    chk("bubble", {63'd0, o_struct.is_valid}, 64'd0);
    for (int k = 0; k <= rdy_dly; k++) begin
      chk("req_valid", {63'd0, dmem_req_valid}, 64'd1);
      chk("req_stall", {63'd0, o_stall}, 64'd1);
      chk("req_addr", dmem_req_addr, {s.mem_addr[63:3], 3'b000});
      chk("req_we", {63'd0, dmem_req_we}, {63'd0, s.mem_wr});
      chk("req_strb", {56'd0, dmem_req_strb}, s.mem_wr ? {56'd0, ref_strb(off, s.mem_size)} : 64'd0);
      if (s.mem_wr) chk("req_wdata", dmem_req_wdata, s.mem_data << (8 * off));
      if (k == rdy_dly) dmem_req_ready = 1'b1;
      @(negedge clk);
    end
    dmem_req_ready = 1'b0;
    if (s.mem_wr) begin
      chk_s("st_out", o_struct, s);
      chk("st_stall", {63'd0, o_stall}, 64'd0);
      chk("st_req_drop", {63'd0, dmem_req_valid}, 64'd0);
      return;
    end
    chk("ld_req_drop", {63'd0, dmem_req_valid}, 64'd0);
    chk("ld_wait_stall", {63'd0, o_stall}, 64'd1);
    for (int k = 0; k < rsp_dly; k++) begin
      @(negedge clk);
      chk("ld_wait_stall", {63'd0, o_stall}, 64'd1);
    end
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = rdata;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    e = s;
    e.rf_wr_data = ref_load(rdata, off, s.mem_size, s.mem_unsigned);
    chk_s("ld_out", o_struct, e);
    chk("ld_stall", {63'd0, o_stall}, 64'd0);
  endtask

  function automatic interconnection_struct mk(input logic rd, input logic wr, input logic [1:0] sz,
                                               input logic uns, input logic [63:0] addr,
                                               input logic [63:0] data);
    interconnection_struct s;
    s = '0;
    s.is_valid = 1'b1; s.pc = 64'h8000_0000 + addr; s.rd = 5'd7; s.rf_wr_en = rd;
    s.mem_rd = rd; s.mem_wr = wr; s.mem_size = sz; s.mem_unsigned = uns;
    s.mem_addr = addr; s.mem_data = data; s.rf_wr_data = 64'h1111;
    return s;
  endfunction

  initial begin
    interconnection_struct s;
    int kind;
    logic [2:0] off;

    rst_n = 1'b0; i_struct = '0; dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;
    #2;
    chk_s("rst_struct", o_struct, '0);
    chk("rst_stall", {63'd0, o_stall}, 64'd0);
    chk("rst_mis", {63'd0, o_misaligned}, 64'd0);
    chk("rst_req", {63'd0, dmem_req_valid}, 64'd0);
    chk("rst_strb", {56'd0, dmem_req_strb}, 64'd0);
    chk("rst_addr", dmem_req_addr, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // ALU op passes straight through
    s = '0; s.is_valid = 1'b1; s.rd = 5'd3; s.rf_wr_en = 1'b1; s.rf_wr_data = 64'h5;
    do_op(s, 0, 0, 64'd0);
    // SD with ready held low for three cycles
    do_op(mk(0, 1, MEM_D, 0, 64'h1000, 64'hDEAD_BEEF_CAFE_F00D), 3, 0, 64'd0);
    // LB / LBU lane extraction and extension
    do_op(mk(1, 0, MEM_B, 0, 64'h1003, 64'd0), 0, 0, 64'h0000_0080_0000_0000);
    do_op(mk(1, 0, MEM_B, 0, 64'h1003, 64'd0), 1, 2, 64'h0000_0000_8000_0000);
    do_op(mk(1, 0, MEM_B, 1, 64'h1003, 64'd0), 0, 1, 64'h0000_0000_8000_0000);
    // Misaligned LW
    do_op(mk(1, 0, MEM_W, 0, 64'h1002, 64'd0), 0, 0, 64'd0);
    // SH in the top lane
    do_op(mk(0, 1, MEM_H, 0, 64'h1006, 64'hABCD), 0, 0, 64'd0);
    // LD full word
    do_op(mk(1, 0, MEM_D, 0, 64'h2008, 64'd0), 2, 0, 64'h0123_4567_89AB_CDEF);

    // Reset during REQ drops the request at once
    @(negedge clk); i_struct = mk(0, 1, MEM_W, 0, 64'h3004, 64'h55);
    @(negedge clk); i_struct = '0;
    chk("pre_rst_req", {63'd0, dmem_req_valid}, 64'd1);
    rst_n = 1'b0; #1;
    chk("rst_req_drop", {63'd0, dmem_req_valid}, 64'd0);
    chk("rst_req_stall", {63'd0, o_stall}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Reset during WAIT; a late response must be ignored
    @(negedge clk); i_struct = mk(1, 0, MEM_D, 0, 64'h4000, 64'd0);
    @(negedge clk); i_struct = '0; dmem_req_ready = 1'b1;
    @(negedge clk); dmem_req_ready = 1'b0;
    chk("wait_stall", {63'd0, o_stall}, 64'd1);
    rst_n = 1'b0; #1;
    chk("rst_wait_stall", {63'd0, o_stall}, 64'd0);
    chk("rst_wait_req", {63'd0, dmem_req_valid}, 64'd0);
    @(negedge clk); rst_n = 1'b1; dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 64'hFFFF;
    @(negedge clk); dmem_rsp_valid = 1'b0;
    chk("late_rsp_valid", {63'd0, o_struct.is_valid}, 64'd0);
    chk("late_rsp_stall", {63'd0, o_stall}, 64'd0);

    // Randomized mix of ALU, load and store ops
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 2));
      s = mk(kind == 1, kind == 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             {$urandom, $urandom}, {$urandom, $urandom});
      off = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) off = off & ~3'((1 << s.mem_size) - 1);
      s.mem_addr[2:0] = off;
      s.is_valid = ($urandom_range(0, 9) != 0);
      s.rf_wr_data = {$urandom, $urandom};
      do_op(s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), {$urandom, $urandom});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
